// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: opcodes, slice select words,
// FSM states, fill modes and opcode classification helpers.
// Optional feature macro: ALU_SEQ_ROTATE_EN (makes ROL/ROR legal opcodes).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_OR   = 4'h1,
    OP_XOR  = 4'h2,
    OP_XNOR = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_INC  = 4'h6,
    OP_DEC  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_ROL  = 4'hA,
    OP_ROR  = 4'hB
  } op_e;

  // Slice select: [4]=shift, [3]=arith, [2:0]=function.
  // Arith: [0]=invert B.  Shift: [0]=direction (0 left, 1 right).
  localparam logic [4:0] SEL_AND  = 5'b0_0_000;
  localparam logic [4:0] SEL_OR   = 5'b0_0_001;
  localparam logic [4:0] SEL_XOR  = 5'b0_0_010;
  localparam logic [4:0] SEL_XNOR = 5'b0_0_011;
  localparam logic [4:0] SEL_ADD  = 5'b0_1_000;
  localparam logic [4:0] SEL_SUB  = 5'b0_1_001;
  localparam logic [4:0] SEL_INC  = 5'b0_1_010;
  localparam logic [4:0] SEL_DEC  = 5'b0_1_011;
  localparam logic [4:0] SEL_SHL  = 5'b1_0_000;
  localparam logic [4:0] SEL_SHR  = 5'b1_0_001;
  localparam logic [4:0] SEL_ROL  = 5'b1_0_010;
  localparam logic [4:0] SEL_ROR  = 5'b1_0_011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Source of the vacated-end bit on a shift pass.
  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_MSB  = 2'd1,
    FILL_LSB  = 2'd2
  } fill_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
`ifdef ALU_SEQ_ROTATE_EN
    return op <= OP_ROR;
`else
    return op <= OP_SHR;
`endif
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Opcode decode for the ALU sequencer: select word, carry-in, B-force,
// fill mode and legality. Rotate entries exist only with ALU_SEQ_ROTATE_EN.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic [4:0] sel,
  output logic       cin,
  output logic       b_zero,
  output logic [1:0] fill_mode,
  output logic       legal,
  output logic       shift
);

  // Pure lookup from opcode to ALU control fields.
  always_comb begin
    sel       = '0;
    cin       = 1'b0;
    b_zero    = 1'b0;
    fill_mode = FILL_ZERO;
    legal     = is_legal(op);
    shift     = is_legal(op) && is_shift(op);
    case (op)
      OP_AND:  sel = SEL_AND;
      OP_OR:   sel = SEL_OR;
      OP_XOR:  sel = SEL_XOR;
      OP_XNOR: sel = SEL_XNOR;
      OP_ADD:  sel = SEL_ADD;
      OP_SUB: begin
        sel = SEL_SUB;
        cin = 1'b1;
      end
      OP_INC: begin
        sel    = SEL_INC;
        cin    = 1'b1;
        b_zero = 1'b1;
      end
      OP_DEC: begin
        sel    = SEL_DEC;
        b_zero = 1'b1;
      end
      OP_SHL:  sel = SEL_SHL;
      OP_SHR:  sel = SEL_SHR;
`ifdef ALU_SEQ_ROTATE_EN
      OP_ROL: begin
        sel       = SEL_ROL;
        fill_mode = FILL_MSB;
      end
      OP_ROR: begin
        sel       = SEL_ROR;
        fill_mode = FILL_LSB;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the 16-bit reversible ALU: accepts a request,
// drives the ALU for one pass (logic/arith) or N single-bit passes (shifts),
// and returns result/flags over a valid/ready response handshake.
// Optional feature macro: ALU_SEQ_ROTATE_EN (ROL/ROR). Without it the decode
// never selects a non-zero fill source, so alu_fill stays 0.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic [4:0]         alu_select,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_cin,
  output logic               alu_fill,
  input  logic [WIDTH-1:0]   alu_y,
  input  logic               alu_cout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_y,
  output logic               rsp_cout,
  output logic               rsp_zero,
  output logic               rsp_err
);

  state_e             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [4:0]         sel_q;
  logic               cin_q;
  logic [1:0]         fill_q;

  logic [4:0]         dec_sel;
  logic               dec_cin;
  logic               dec_b_zero;
  logic [1:0]         dec_fill;
  logic               dec_legal;
  logic               dec_shift;

  alu_seq_decode u_decode (
    .op        (req_op),
    .sel       (dec_sel),
    .cin       (dec_cin),
    .b_zero    (dec_b_zero),
    .fill_mode (dec_fill),
    .legal     (dec_legal),
    .shift     (dec_shift)
  );

  // ALU lines carry the latched operation only while a pass is in progress.
  always_comb begin
    alu_select = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    alu_fill   = 1'b0;
    if ((state == ST_EXEC) || (state == ST_SHIFT)) begin
      alu_select = sel_q;
      alu_a      = a_q;
      alu_b      = b_q;
      alu_cin    = cin_q;
      case (fill_q)
        FILL_MSB: alu_fill = a_q[WIDTH-1];
        FILL_LSB: alu_fill = a_q[0];
        default:  alu_fill = 1'b0;
      endcase
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b1;
      rsp_err   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      cin_q     <= 1'b0;
      fill_q    <= FILL_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_q       <= req_a;
            b_q       <= dec_b_zero ? '0 : req_b;
            cnt_q     <= req_b[SHAMT_W-1:0];
            sel_q     <= dec_sel;
            cin_q     <= dec_cin;
            fill_q    <= dec_fill;
            req_ready <= 1'b0;
            if (!dec_legal) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_y     <= '0;
              rsp_cout  <= 1'b0;
              rsp_zero  <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (dec_shift) begin
              if (req_b[SHAMT_W-1:0] == '0) begin
                state     <= ST_RESP;
                rsp_valid <= 1'b1;
                rsp_y     <= req_a;
                rsp_cout  <= 1'b0;
                rsp_zero  <= (req_a == '0);
                rsp_err   <= 1'b0;
              end else begin
                state <= ST_SHIFT;
              end
            end else begin
              state <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_y     <= alu_y;
          rsp_cout  <= alu_cout;
          rsp_zero  <= (alu_y == '0);
          rsp_err   <= 1'b0;
        end

        // The final pass's carry-out is the last bit shifted out, so it is
        // captured straight into rsp_cout rather than a separate register.
        ST_SHIFT: begin
          a_q <= alu_y;
          if (cnt_q == SHAMT_W'(1)) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_y     <= alu_y;
            rsp_cout  <= alu_cout;
            rsp_zero  <= (alu_y == '0);
            rsp_err   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - SHAMT_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU attached.
// Expected responses come from an arithmetic reference model of each opcode.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned W = 16;

`ifdef ALU_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] y;
    logic         cout;
    logic         zero;
    logic         err;
    int unsigned  lat;
    int unsigned  acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [4:0]   alu_select;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_cin;
  logic         alu_fill;
  logic [W-1:0] alu_y;
  logic         alu_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_cout;
  logic         rsp_zero;
  logic         rsp_err;

  logic [W:0]   alu_sum;
  int unsigned  tests = 0;
  int unsigned  fails = 0;
  int unsigned  cyc = 0;
  exp_t         expq[$];

  alu_op_sequencer #(.WIDTH(W), .SHAMT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_select (alu_select),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_fill   (alu_fill),
    .alu_y      (alu_y),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_cout   (rsp_cout),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU datapath slice
  always_comb begin
    alu_sum  = '0;
    alu_y    = '0;
    alu_cout = 1'b0;
    if (alu_select[4]) begin
      if (!alu_select[0]) begin
        alu_y    = {alu_a[W-2:0], alu_fill};
        alu_cout = alu_a[W-1];
      end else begin
        alu_y    = {alu_fill, alu_a[W-1:1]};
        alu_cout = alu_a[0];
      end
    end else if (alu_select[3]) begin
      alu_sum  = {1'b0, alu_a} + {1'b0, (alu_select[0] ? ~alu_b : alu_b)} + {{W{1'b0}}, alu_cin};
      alu_y    = alu_sum[W-1:0];
      alu_cout = alu_sum[W];
    end else begin
      case (alu_select[1:0])
        2'b00:   alu_y = alu_a & alu_b;
        2'b01:   alu_y = alu_a | alu_b;
        2'b10:   alu_y = alu_a ^ alu_b;
        default: alu_y = ~(alu_a ^ alu_b);
      endcase
    end
  end

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int unsigned n;
    logic [31:0] s;
    logic        bad;
    n      = 32'(b[3:0]);
    s      = 32'(a) + 32'(b);
    e.y    = '0;
    e.cout = 1'b0;
    e.err  = 1'b0;
    e.lat  = 2;
    e.acc  = 0;
    bad    = 1'b0;
    case (op)
      4'h0: e.y = a & b;
      4'h1: e.y = a | b;
      4'h2: e.y = a ^ b;
      4'h3: e.y = ~(a ^ b);
      4'h4: begin e.y = s[W-1:0]; e.cout = s[W]; end
      4'h5: begin e.y = a - b; e.cout = (a >= b); end
      4'h6: begin e.y = a + W'(1); e.cout = (a == {W{1'b1}}); end
      4'h7: begin e.y = a - W'(1); e.cout = (a != '0); end
      4'h8, 4'h9, 4'hA, 4'hB: begin
        if ((op == 4'hA || op == 4'hB) && !ROT_EN) bad = 1'b1;
        else if (n == 0) begin
          e.y   = a;
          e.lat = 1;
        end else begin
          e.lat = n + 1;
          case (op)
            4'h8: begin e.y = a << n; e.cout = a[W-n]; end
            4'h9: begin e.y = a >> n; e.cout = a[n-1]; end
            4'hA: begin e.y = (a << n) | (a >> (W - n)); e.cout = a[W-n]; end
            default: begin e.y = (a >> n) | (a << (W - n)); e.cout = a[n-1]; end
          endcase
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      e.y    = '0;
      e.cout = 1'b0;
      e.err  = 1'b1;
      e.lat  = 1;
    end
    e.zero = (e.y == '0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  // Monitor: one scoreboard pop per presented response.
  initial begin : monitor
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !rsp_valid) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 y=%0h, expected no response", rsp_y);
        end else begin
          e = expq.pop_front();
          chk("rsp_y",    32'(rsp_y),    32'(e.y));
          chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          chk("rsp_err",  32'(rsp_err),  32'(e.err));
          chk("latency",  cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    e     = model(op, a, b);
    e.acc = cyc;
    expq.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic complete(input int unsigned delay, input bit hold_chk, input logic [W-1:0] hold_y);
    int unsigned k;
    k = 0;
    while (!rsp_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got no rsp_valid in 64 cycles, expected a response");
      expq.delete();
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      return;
    end
    for (int unsigned i = 0; i < delay; i++) begin
      @(negedge clk);
      if (hold_chk) begin
        chk("hold_rsp_y",     32'(rsp_y),     32'(hold_y));
        chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (hold_chk) begin
      chk("post_hs_req_ready", 32'(req_ready), 32'd1);
      chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned delay);
    issue(op, a, b);
    complete(delay, 1'b0, '0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_rsp_y"},      32'(rsp_y),      32'd0);
    chk({tag, "_rsp_cout"},   32'(rsp_cout),   32'd0);
    chk({tag, "_rsp_zero"},   32'(rsp_zero),   32'd1);
    chk({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    chk({tag, "_alu_select"}, 32'(alu_select), 32'd0);
    chk({tag, "_alu_a"},      32'(alu_a),      32'd0);
    chk({tag, "_alu_b"},      32'(alu_b),      32'd0);
    chk({tag, "_alu_cin"},    32'(alu_cin),    32'd0);
    chk({tag, "_alu_fill"},   32'(alu_fill),   32'd0);
  endtask

  initial begin : driver
    logic [3:0] op;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #12;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    run(OP_ADD, 16'hFFFF, 16'h0001, 0);
    run(OP_SHL, 16'h8001, 16'h0003, 1);
    run(OP_SHL, 16'h8001, 16'h0000, 0);
    run(OP_ROR, 16'h0001, 16'h0001, 0);
    run(OP_ROL, 16'h8000, 16'h0001, 2);
    run(OP_SUB, 16'h0003, 16'h0005, 0);
    run(OP_DEC, 16'h0000, 16'h1234, 0);
    run(OP_INC, 16'hFFFF, 16'h1234, 0);
    run(OP_SHR, 16'h8001, 16'h000F, 0);

    // Response held off for 10 cycles must stay stable
    issue(OP_XOR, 16'h00FF, 16'h0F0F);
    complete(10, 1'b1, 16'h0FF0);

    // Reset during the third pass of an 8-bit shift drops the request
    issue(OP_SHR, 16'hA5C3, 16'h0008);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(OP_ADD, 16'h1234, 16'h4321, 0);

    run(4'hF, 16'h1234, 16'h5678, 0);
    run(4'hC, 16'hFFFF, 16'h0001, 1);

    for (int unsigned i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(12, 15));
      else op = 4'($urandom_range(0, 11));
      run(op, W'($urandom), W'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    summary();
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion by %0t, expected bench to finish", $time);
    fails++;
    summary();
    $fatal(1, "watchdog expired");
  end

endmodule
